cpu_controller: RTL and testbench



---
 rtl/cpu_controller_pkg.sv | 36 +++
 rtl/cpu_controller.sv | 100 ++++++++++
 tb/tb_cpu_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the RISC CPU control path: opcode and phase encodings.
package cpu_controller_pkg;

  localparam logic [2:0] OPCODE_HLT = 3'd0;
  localparam logic [2:0] OPCODE_SKZ = 3'd1;
  localparam logic [2:0] OPCODE_ADD = 3'd2;
  localparam logic [2:0] OPCODE_AND = 3'd3;
  localparam logic [2:0] OPCODE_XOR = 3'd4;
  localparam logic [2:0] OPCODE_LDA = 3'd5;
  localparam logic [2:0] OPCODE_STO = 3'd6;
  localparam logic [2:0] OPCODE_JMP = 3'd7;

  typedef enum logic [2:0] {
    PHASE_INST_ADDR  = 3'd0,
    PHASE_INST_FETCH = 3'd1,
    PHASE_INST_LOAD  = 3'd2,
    PHASE_IDLE       = 3'd3,
    PHASE_OP_ADDR    = 3'd4,
    PHASE_OP_FETCH   = 3'd5,
    PHASE_ALU_OP     = 3'd6,
    PHASE_STORE      = 3'd7
  } phase_e;

  // Opcodes whose result is written back into the accumulator.
  // Unknown opcodes fall to the default and count as non-ALU.
  function automatic logic is_aluop(input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OPCODE_ADD, OPCODE_AND, OPCODE_XOR, OPCODE_LDA: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: phase counter, sticky halt flag and
// a purely combinational strobe decode of phase/opcode/zero.
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       wr,
  output logic       data_e,
  output logic       halt
);

  phase_e     phase_q, phase_d;
  logic       halted_q, halted_d;
  logic [2:0] phase_inc;
  logic       aluop;

  // Phase and halt state; reset returns to instruction-address phase at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PHASE_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next state: free-running wrap 7->0; HLT leaving phase 4 freezes at phase 5.
  always_comb begin
    phase_inc = phase_q + 3'd1;
    phase_d   = phase_e'(phase_inc);
    halted_d  = halted_q;
    if (halted_q) begin
      phase_d = phase_q;
    end else if (phase_q == PHASE_OP_ADDR && opcode == OPCODE_HLT) begin
      halted_d = 1'b1;
    end
  end

  // Strobe decode; opcode-dependent strobes only matter in phases 4..7.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    aluop  = is_aluop(opcode);
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        PHASE_INST_ADDR:  sel = 1'b1;
        PHASE_INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        PHASE_INST_LOAD,
        PHASE_IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        PHASE_OP_ADDR: begin
          inc_pc = 1'b1;
          case (opcode)
            OPCODE_HLT: halt = 1'b1;
            default:    halt = 1'b0;
          endcase
        end
        PHASE_OP_FETCH: rd = aluop;
        PHASE_ALU_OP: begin
          rd = aluop;
          case (opcode)
            OPCODE_SKZ: inc_pc = zero;
            OPCODE_JMP: ld_pc  = 1'b1;
            OPCODE_STO: data_e = 1'b1;
            default:    ;
          endcase
        end
        PHASE_STORE: begin
          rd    = aluop;
          ld_ac = aluop;
          case (opcode)
            OPCODE_JMP: ld_pc = 1'b1;
            OPCODE_STO: begin wr = 1'b1; data_e = 1'b1; end
            default:    ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed instruction sequences plus
// random instruction streams against a cycle-level behavioural model.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt;

  int compared = 0;
  int mism     = 0;
  int mph      = 0;   // model phase 0..7
  bit mhalt    = 0;   // model halted flag
  int inc_cnt  = 0;   // inc_pc pulses seen in the current instruction

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDI = 3'd3,
                         XORI = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc),
    .inc_pc(inc_pc), .wr(wr), .data_e(data_e), .halt(halt)
  );

  always #5 clk = ~clk;

  // Expected strobes {sel,rd,ld_ir,ld_ac,ld_pc,inc_pc,wr,data_e,halt}
  // straight from the per-phase rules.
  function automatic logic [8:0] exp_out(input int ph, input bit h,
                                         input logic [2:0] op, input logic z);
    bit alu, e_sel, e_rd, e_ir, e_ac, e_pc, e_inc, e_wr, e_de, e_h;
    if (h) return 9'b0_0000_0001;
    alu   = (op === ADD) || (op === ANDI) || (op === XORI) || (op === LDA);
    e_sel = (ph < 4);
    e_rd  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    e_ir  = (ph == 2 || ph == 3);
    e_ac  = (ph == 7) && alu;
    e_pc  = (ph == 6 || ph == 7) && (op === JMP);
    e_inc = (ph == 4) || (ph == 6 && op === SKZ && z === 1'b1);
    e_wr  = (ph == 7) && (op === STO);
    e_de  = (ph == 6 || ph == 7) && (op === STO);
    e_h   = (ph == 4) && (op === HLT);
    return {e_sel, e_rd, e_ir, e_ac, e_pc, e_inc, e_wr, e_de, e_h};
  endfunction

  // One clock: drive at negedge, check 1ns later, advance model on posedge.
  task automatic step(input logic [2:0] op, input logic z, input string tag);
    logic [8:0] obs, ex;
    opcode = op;
    zero   = z;
    #1;
    if (rst) begin mph = 0; mhalt = 0; end
    obs = {sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt};
    ex  = exp_out(mph, mhalt, op, z);
    compared++;
    assert (obs === ex) else begin
      mism++;
      $error("FAIL %s ph%0d op%0d z%0b: got %b want %b", tag, mph, op, z, obs, ex);
    end
    compared++;
    assert (((wr && rd) || (ld_ir && (ld_ac || ld_pc))) === 1'b0) else begin
      mism++;
      $error("FAIL %s exclusivity ph%0d: got wr%b rd%b ld_ir%b ld_ac%b ld_pc%b want no overlap",
             tag, mph, wr, rd, ld_ir, ld_ac, ld_pc);
    end
    if (inc_pc) inc_cnt++;
    @(posedge clk);
    if (!rst && !mhalt) begin
      if (mph == 4 && op === HLT) mhalt = 1;
      mph = (mph + 1) % 8;
    end
    @(negedge clk);
  endtask

  // One instruction from the current phase until the next wrap to phase 0.
  // Random opcode noise in phases 0..3; zmode 0/1 forces zero in phase 6, 2 = random.
  task automatic run_instr(input logic [2:0] op, input int zmode, input string tag);
    logic [2:0] o;
    logic       z;
    inc_cnt = 0;
    for (int p = 0; p < 8; p++) begin
      o = (mph < 4) ? 3'($urandom_range(0, 7)) : op;
      z = 1'($urandom_range(0, 1));
      if (mph == 6 && zmode < 2) z = zmode[0];
      step(o, z, tag);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step(3'($urandom_range(0, 7)), 1'b0, tag);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] rop;
    rst = 1'b1; opcode = ADD; zero = 1'b0;
    @(negedge clk);
    step(ADD, 1'b0, "reset_state");
    rst = 1'b0;

    // Fetch sequence and each opcode class
    run_instr(ADD,  2, "add");
    run_instr(ANDI, 2, "and");
    run_instr(XORI, 2, "xor");
    run_instr(LDA,  2, "lda");
    run_instr(STO,  2, "sto");
    run_instr(JMP,  2, "jmp");

    // SKZ: two increments when zero, one otherwise
    run_instr(SKZ, 1, "skz_z1");
    compared++;
    assert (inc_cnt === 2) else begin
      mism++; $error("FAIL skz_z1_pulses: got %0d want 2", inc_cnt);
    end
    run_instr(SKZ, 0, "skz_z0");
    compared++;
    assert (inc_cnt === 1) else begin
      mism++; $error("FAIL skz_z0_pulses: got %0d want 1", inc_cnt);
    end

    // Reset asserted in phase 5 of an ADD
    for (int p = 0; p < 5; p++) step(p < 4 ? 3'($urandom_range(0, 7)) : ADD, 1'b0, "pre_rst");
    compared++;
    assert (mph === 5) else begin
      mism++; $error("FAIL rst_mid_phase: got phase %0d want 5", mph);
    end
    opcode = ADD;
    do_reset("rst_mid");
    run_instr(ADD, 2, "after_rst");

    // HLT: halts and stays halted until reset
    run_instr(HLT, 2, "hlt");
    for (int i = 0; i < 22; i++) step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "halted");
    compared++;
    assert (halt === 1'b1) else begin
      mism++; $error("FAIL halt_sticky: got %b want 1", halt);
    end
    do_reset("hlt_rst");
    compared++;
    assert ({halt, sel} === 2'b01) else begin
      mism++; $error("FAIL hlt_cleared: got halt%b sel%b want halt0 sel1", halt, sel);
    end
    run_instr(JMP, 2, "resume");

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      rop = ($urandom_range(0, 15) == 0) ? HLT : 3'($urandom_range(1, 7));
      run_instr(rop, 2, "rand");
      if (mhalt) begin
        for (int i = 0; i < 3; i++) step(3'($urandom_range(0, 7)), 1'b1, "rand_halted");
        do_reset("rand_rst");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
